// File: rtl/bist_controller_if.sv
// Control bundle between the BIST sequencer, its pattern/address datapath
// and the system status logic.
interface bist_controller_if;
    logic error;
    logic pat_end;
    logic count_end;
    logic nxt_pat;
    logic nxt_count;
    logic tst_state;
    logic tst_pass;
    logic tst_fail;
    logic rst_count;
    logic rst_pat;

    modport master (
        input  error,
        input  pat_end,
        input  count_end,
        output nxt_pat,
        output nxt_count,
        output tst_state,
        output tst_pass,
        output tst_fail,
        output rst_count,
        output rst_pat
    );

    modport slave (
        output error,
        output pat_end,
        output count_end,
        input  nxt_pat,
        input  nxt_count,
        input  tst_state,
        input  tst_pass,
        input  tst_fail,
        input  rst_count,
        input  rst_pat
    );
endinterface

// File: rtl/bist_controller.sv
// RAM BIST sequencer: walks every (pattern, address) pair and latches a
// sticky pass/fail verdict. Moore FSM with registered outputs.
module bist_controller #(
    parameter int START_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    bist_controller_if.master  bus
);
    localparam int CW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        TEST     = 3'd1,
        NEXT_PAT = 3'd2,
        PASS     = 3'd3,
        FAIL     = 3'd4
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        nxt     = state;
        cnt_nxt = '0;
        if (!rst) begin
            nxt = INIT;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == CW'(START_DELAY)) begin
                        nxt = TEST;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                TEST: begin
                    if (bus.error) begin
                        nxt = FAIL;
                    end else if (bus.count_end && bus.pat_end) begin
                        nxt = PASS;
                    end else if (bus.count_end) begin
                        nxt = NEXT_PAT;
                    end
                end
                // Compare data is not valid while the pattern advances.
                NEXT_PAT: nxt = TEST;
                PASS:     nxt = PASS;
                FAIL:     nxt = FAIL;
                default:  nxt = INIT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        state         <= nxt;
        cnt           <= cnt_nxt;
        bus.nxt_pat   <= (nxt == NEXT_PAT);
        bus.nxt_count <= (nxt == TEST);
        bus.tst_state <= (nxt == TEST) || (nxt == NEXT_PAT);
        bus.tst_pass  <= (nxt == PASS);
        bus.tst_fail  <= (nxt == FAIL);
        bus.rst_count <= (nxt == INIT) || (nxt == NEXT_PAT);
        bus.rst_pat   <= (nxt == INIT);
    end
endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: directed vectors push expected
// output words, a monitor pops and compares after every rising edge.
module tb_bist_controller;
    logic clk;
    logic rst;

    bist_controller_if bus ();

    bist_controller #(.START_DELAY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {nxt_pat, nxt_count, tst_state, tst_pass, tst_fail, rst_count, rst_pat}
    localparam logic [6:0] E_INIT = 7'b0000011;
    localparam logic [6:0] E_TEST = 7'b0110000;
    localparam logic [6:0] E_NP   = 7'b1010010;
    localparam logic [6:0] E_PASS = 7'b0001000;
    localparam logic [6:0] E_FAIL = 7'b0000100;

    logic [6:0] exp_q[$];
    string      name_q[$];
    int         total;
    int         passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always begin
        logic [6:0] got;
        logic [6:0] exp;
        string      nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp  = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {bus.nxt_pat, bus.nxt_count, bus.tst_state,
                    bus.tst_pass, bus.tst_fail, bus.rst_count, bus.rst_pat};
            total++;
            if (got !== exp) begin
                $display("FAIL %s: got %b expected %b", nm, got, exp);
            end else begin
                passed++;
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic ce,
                        input logic pe, input logic [6:0] exp,
                        input string nm);
        @(negedge clk);
        rst           = r;
        bus.error     = e;
        bus.count_end = ce;
        bus.pat_end   = pe;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic start_up();
        step(1'b1, 1'b1, 1'b0, 1'b0, E_INIT, "init_delay1");
        step(1'b1, 1'b1, 1'b1, 1'b0, E_INIT, "init_delay2");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TEST, "enter_test");
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        rst           = 1'b0;
        bus.error     = 1'b0;
        bus.count_end = 1'b0;
        bus.pat_end   = 1'b0;

        // Reset held three clocks, inputs noisy
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, E_INIT, "reset");
        end

        start_up();
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TEST, "test_hold1");
        step(1'b1, 1'b0, 1'b0, 1'b1, E_TEST, "test_hold2");

        // Pattern step; error during NEXT_PAT must be ignored
        step(1'b1, 1'b0, 1'b1, 1'b0, E_NP,   "next_pat");
        step(1'b1, 1'b1, 1'b1, 1'b1, E_TEST, "np_back_test");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TEST, "test_after_np");

        // Pass and stickiness
        step(1'b1, 1'b0, 1'b1, 1'b1, E_PASS, "pass");
        for (int i = 0; i < 11; i++) begin
            step(1'b1, i[0], i[1], i[2], E_PASS, "pass_sticky");
        end

        // Reset from PASS, restart, then fail
        step(1'b0, 1'b0, 1'b0, 1'b0, E_INIT, "reset_from_pass");
        start_up();
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TEST, "test_run");
        step(1'b1, 1'b1, 1'b0, 1'b0, E_FAIL, "fail");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, E_FAIL, "fail_sticky");
        end

        // Reset mid-test from TEST
        step(1'b0, 1'b0, 1'b0, 1'b0, E_INIT, "reset_from_fail");
        start_up();
        step(1'b0, 1'b0, 1'b0, 1'b0, E_INIT, "reset_mid_test");
        start_up();

        // Error wins over count_end and pat_end
        step(1'b1, 1'b1, 1'b1, 1'b1, E_FAIL, "error_priority");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_FAIL, "fail_hold");

        // One-cycle reset, clean re-run through two patterns to pass
        step(1'b0, 1'b1, 1'b1, 1'b1, E_INIT, "reset_1cyc");
        start_up();
        step(1'b1, 1'b0, 1'b1, 1'b0, E_NP,   "rerun_np1");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_TEST, "rerun_test1");
        step(1'b1, 1'b0, 1'b1, 1'b0, E_NP,   "rerun_np2");
        step(1'b1, 1'b0, 1'b1, 1'b1, E_TEST, "rerun_test2");
        step(1'b1, 1'b0, 1'b1, 1'b1, E_PASS, "rerun_pass");
        step(1'b1, 1'b1, 1'b0, 1'b0, E_PASS, "rerun_pass_hold");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
